// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and synchronizer depth.
// Used by both the I2C target and the I2C master.
package i2c_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK
    } state_t;

endpackage

// File: rtl/i2c_target_if.sv
// Pin and local register-file bundle of the I2C target.
interface i2c_target_if;

    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, reg_rdata,
        output sda_oe, reg_addr, reg_wr, reg_wdata, reg_rd, busy
    );

    modport master (
        output scl_i, sda_i, reg_rdata,
        input  sda_oe, reg_addr, reg_wr, reg_wdata, reg_rd, busy
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Pin synchronizer with rise/fall detection against one delayed flop.
module i2c_sync_edge
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;

    // Reset to the idle-high bus level so no phantom edge follows reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync <= '1;
            dly  <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            dly  <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~dly;
    assign fall  = ~level & dly;

endmodule

// File: rtl/i2c_target.sv
// I2C target: START/STOP decode, 7-bit address match, auto-increment
// register pointer and byte-wide strobes to a local register file.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         CLK_FREQ    = 100_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    i2c_target_if.slave  bus
);

    if (CLK_FREQ < 2_000_000) begin : g_clk_check
        $error("CLK_FREQ too low for standard-mode SCL");
    end

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.scl_i),
        .level   (scl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.sda_i),
        .level   (sda),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic       rw;
    logic       acked;
    logic [7:0] rx_byte;
    logic       start_c;
    logic       stop_c;

    assign rx_byte = {shreg[6:0], sda};
    assign start_c = sda_fall & scl;
    assign stop_c  = sda_rise & scl;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bitcnt        <= '0;
            rw            <= 1'b0;
            acked         <= 1'b0;
            bus.sda_oe    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wr    <= 1'b0;
            bus.reg_wdata <= '0;
            bus.reg_rd    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.reg_wr <= 1'b0;
            bus.reg_rd <= 1'b0;
            // Read data arrives the clock after the strobe.
            if (bus.reg_rd) shreg <= bus.reg_rdata;

            if (start_c) begin
                state      <= ST_ADDR;
                bitcnt     <= '0;
                acked      <= 1'b0;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
            end else if (stop_c) begin
                state      <= ST_IDLE;
                acked      <= 1'b0;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: ;
                    ST_ADDR: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                state      <= ST_ADDR_ACK;
                                bus.busy   <= 1'b1;
                                rw         <= rx_byte[0];
                                bus.reg_rd <= rx_byte[0];
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    // First fall drives ACK, second fall releases it.
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!bus.sda_oe) begin
                            bus.sda_oe <= 1'b1;
                        end else begin
                            bitcnt <= '0;
                            if (rw) begin
                                state      <= ST_RDATA;
                                bus.sda_oe <= ~shreg[7];
                                shreg      <= {shreg[6:0], 1'b0};
                            end else begin
                                state      <= ST_PTR;
                                bus.sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_PTR: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            bus.reg_addr <= rx_byte;
                            state        <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK: if (scl_fall) begin
                        if (!bus.sda_oe) begin
                            bus.sda_oe <= 1'b1;
                        end else begin
                            bus.sda_oe <= 1'b0;
                            bitcnt     <= '0;
                            state      <= ST_WDATA;
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            bus.reg_wr    <= 1'b1;
                            bus.reg_wdata <= rx_byte;
                            state         <= ST_WACK;
                        end
                    end
                    ST_WACK: if (scl_fall) begin
                        if (!bus.sda_oe) begin
                            bus.sda_oe <= 1'b1;
                        end else begin
                            bus.sda_oe   <= 1'b0;
                            bitcnt       <= '0;
                            bus.reg_addr <= bus.reg_addr + 8'd1;
                            state        <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_fall) begin
                            bus.sda_oe <= ~shreg[7];
                            shreg      <= {shreg[6:0], 1'b0};
                        end
                        if (scl_rise) begin
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) state <= ST_RACK;
                        end
                    end
                    // Pointer moves past every byte sent; only ACK fetches more.
                    ST_RACK: begin
                        if (scl_rise) begin
                            bus.reg_addr <= bus.reg_addr + 8'd1;
                            if (!sda) begin
                                acked      <= 1'b1;
                                bus.reg_rd <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        if (scl_fall) begin
                            if (acked) begin
                                acked      <= 1'b0;
                                bitcnt     <= '0;
                                state      <= ST_RDATA;
                                bus.sda_oe <= ~shreg[7];
                                shreg      <= {shreg[6:0], 1'b0};
                            end else begin
                                bus.sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged master plus
// scoreboards for register write and read strobes.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [7:0]  mem [256];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [15:0] exp_w;
    logic [7:0]  exp_r;
    logic        oe_seen = 1'b0;

    i2c_target_if bus ();

    assign bus.scl_i     = scl_m;
    assign bus.sda_i     = sda_m & ~bus.sda_oe;
    assign bus.reg_rdata = mem[bus.reg_addr];

    i2c_target #(
        .TARGET_ADDR (7'h50),
        .CLK_FREQ    (100_000_000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sda_oe) oe_seen = 1'b1;
        if (reset_n && bus.reg_wr) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_strobe got addr=%h data=%h expected none",
                         bus.reg_addr, bus.reg_wdata);
            end else begin
                exp_w = wr_q.pop_front();
                if ({bus.reg_addr, bus.reg_wdata} !== exp_w) begin
                    failures++;
                    $display("FAIL wr_strobe got addr=%h data=%h expected addr=%h data=%h",
                             bus.reg_addr, bus.reg_wdata, exp_w[15:8], exp_w[7:0]);
                end
            end
        end
        if (reset_n && bus.reg_rd) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_strobe got addr=%h expected none", bus.reg_addr);
            end else begin
                exp_r = rd_q.pop_front();
                if (bus.reg_addr !== exp_r) begin
                    failures++;
                    $display("FAIL rd_strobe got addr=%h expected %h",
                             bus.reg_addr, exp_r);
                end
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        #1 b = bus.sda_i;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (bus.sda_oe !== 1'b0) begin
            failures++; $display("FAIL rst_sda_oe got %b expected 0", bus.sda_oe);
        end
        if (bus.reg_addr !== 8'h00) begin
            failures++; $display("FAIL rst_reg_addr got %h expected 00", bus.reg_addr);
        end
        if (bus.reg_wr !== 1'b0) begin
            failures++; $display("FAIL rst_reg_wr got %b expected 0", bus.reg_wr);
        end
        if (bus.reg_rd !== 1'b0) begin
            failures++; $display("FAIL rst_reg_rd got %b expected 0", bus.reg_rd);
        end
        if (bus.reg_wdata !== 8'h00) begin
            failures++; $display("FAIL rst_reg_wdata got %h expected 00", bus.reg_wdata);
        end
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL rst_busy got %b expected 0", bus.busy);
        end
        reset_n = 1'b1;
        wait_q();
    endtask

    task automatic test_write();
        logic [7:0] seq [4];
        logic       ack;
        seq = '{8'hA0, 8'h05, 8'h11, 8'h22};
        wr_q.push_back({8'h05, 8'h11});
        wr_q.push_back({8'h06, 8'h22});
        i2c_start();
        foreach (seq[i]) begin
            write_byte(seq[i], ack);
            checks++;
            if (ack !== 1'b0) begin
                failures++;
                $display("FAIL write_ack byte=%h got %b expected 0", seq[i], ack);
            end
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL write_busy got %b expected 1", bus.busy);
        end
        i2c_stop();
        wait_q();
        checks += 3;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL write_busy_end got %b expected 0", bus.busy);
        end
        if (wr_q.size() != 0) begin
            failures++; $display("FAIL write_pending got %0d expected 0", wr_q.size());
        end
        if (bus.reg_addr !== 8'h07) begin
            failures++; $display("FAIL write_ptr got %h expected 07", bus.reg_addr);
        end
    endtask

    task automatic test_read();
        logic [7:0] v;
        logic       ack;
        int         nacks;
        nacks = 0;
        mem[8'h10] = 8'h3C;
        mem[8'h11] = 8'h5A;
        rd_q.push_back(8'h10);
        rd_q.push_back(8'h11);
        i2c_start();
        write_byte(8'hA0, ack); nacks += int'(ack);
        write_byte(8'h10, ack); nacks += int'(ack);
        i2c_start();
        write_byte(8'hA1, ack); nacks += int'(ack);
        checks++;
        if (nacks != 0) begin
            failures++; $display("FAIL read_acks got %0d nacks expected 0", nacks);
        end
        read_byte(v);
        write_bit(1'b0);
        checks++;
        if (v !== 8'h3C) begin
            failures++; $display("FAIL read_byte0 got %h expected 3c", v);
        end
        read_byte(v);
        write_bit(1'b1);
        checks++;
        if (v !== 8'h5A) begin
            failures++; $display("FAIL read_byte1 got %h expected 5a", v);
        end
        i2c_stop();
        wait_q();
        checks += 2;
        if (bus.reg_addr !== 8'h12) begin
            failures++; $display("FAIL read_ptr got %h expected 12", bus.reg_addr);
        end
        if (rd_q.size() != 0) begin
            failures++; $display("FAIL read_pending got %0d expected 0", rd_q.size());
        end
    endtask

    task automatic test_mismatch();
        logic ack;
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, ack);
        i2c_stop();
        wait_q();
        checks += 3;
        if (ack !== 1'b1) begin
            failures++; $display("FAIL mismatch_ack got %b expected 1", ack);
        end
        if (oe_seen !== 1'b0) begin
            failures++; $display("FAIL mismatch_sda_oe got %b expected 0", oe_seen);
        end
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL mismatch_busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4];
        logic       ack;
        int         nacks;
        nacks = 0;
        seq = '{8'hA0, 8'hFF, 8'h01, 8'h02};
        wr_q.push_back({8'hFF, 8'h01});
        wr_q.push_back({8'h00, 8'h02});
        i2c_start();
        foreach (seq[i]) begin
            write_byte(seq[i], ack);
            nacks += int'(ack);
        end
        i2c_stop();
        wait_q();
        checks += 3;
        if (nacks != 0) begin
            failures++; $display("FAIL wrap_acks got %0d nacks expected 0", nacks);
        end
        if (bus.reg_addr !== 8'h01) begin
            failures++; $display("FAIL wrap_ptr got %h expected 01", bus.reg_addr);
        end
        if (wr_q.size() != 0) begin
            failures++; $display("FAIL wrap_pending got %0d expected 0", wr_q.size());
        end
    endtask

    task automatic test_abort();
        logic ack;
        int   nacks;
        nacks = 0;
        i2c_start();
        write_byte(8'hA0, ack); nacks += int'(ack);
        write_byte(8'h20, ack); nacks += int'(ack);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        i2c_stop();
        wait_q();
        checks += 4;
        if (nacks != 0) begin
            failures++; $display("FAIL abort_acks got %0d nacks expected 0", nacks);
        end
        if (dut.state !== ST_IDLE) begin
            failures++; $display("FAIL abort_state got %0d expected %0d", dut.state, ST_IDLE);
        end
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL abort_busy got %b expected 0", bus.busy);
        end
        if (bus.reg_addr !== 8'h20) begin
            failures++; $display("FAIL abort_ptr got %h expected 20", bus.reg_addr);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        logic       ack;
        int         n;
        a = 8'hA0;
        n = 0;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        while (!bus.sda_oe && n < 50) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (bus.sda_oe !== 1'b1) begin
            failures++; $display("FAIL rstmid_ack_drive got %b expected 1", bus.sda_oe);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.sda_oe !== 1'b0) begin
            failures++; $display("FAIL rstmid_sda_oe got %b expected 0", bus.sda_oe);
        end
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_busy got %b expected 0", bus.busy);
        end
        reset_n = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_q();
        wait_q();
        i2c_start();
        write_byte(8'hA0, ack);
        i2c_stop();
        wait_q();
        checks++;
        if (ack !== 1'b0) begin
            failures++; $display("FAIL rstmid_readdr_ack got %b expected 0", ack);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
